// File: rtl/serial_frame_scheduler.sv
// serial_frame_scheduler: feeds frames bit-serially to a sequence recognizer and reports its hits
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready     frame handshake; in_data (MSB first) and in_len (0..DATA_W, clamped)
//   rec_x, rec_clr_n      serial bit and active-low clear to the recognizer
//   rec_z                 Mealy match from the recognizer, sampled only while shifting
//   out_valid/out_ready   result handshake; out_hits (saturating), out_found, out_first
module serial_frame_scheduler #(
   parameter int DATA_W     = 8,
   parameter int CLR_CYCLES = 1
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [DATA_W-1:0]         in_data,
   input  logic [$clog2(DATA_W):0]   in_len,
   output logic                      rec_x,
   output logic                      rec_clr_n,
   input  logic                      rec_z,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [3:0]                out_hits,
   output logic                      out_found,
   output logic [$clog2(DATA_W)-1:0] out_first
);
   localparam int LW = $clog2(DATA_W) + 1;
   localparam int IW = $clog2(DATA_W);
   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] CLEAR  = 2'd1;
   localparam logic [1:0] SHIFT  = 2'd2;
   localparam logic [1:0] REPORT = 2'd3;
   logic [1:0]        r_state;
   logic [DATA_W-1:0] r_sh;
   logic [LW-1:0]     r_len;
   logic [3:0]        r_cnt;
   logic [IW-1:0]     r_idx;
   logic [3:0]        r_hits;
   logic              r_found;
   logic [IW-1:0]     r_first;
   logic [LW-1:0]     w_len;
   assign w_len     = (in_len > LW'(DATA_W)) ? LW'(DATA_W) : in_len;
   // reset gates the handshake and holds the recognizer cleared without waiting for a clock
   assign in_ready  = reset & (r_state == IDLE);
   assign rec_clr_n = reset & (r_state != CLEAR);
   assign rec_x     = (r_state == SHIFT) & r_sh[DATA_W-1];
   assign out_valid = (r_state == REPORT);
   assign out_hits  = r_hits;
   assign out_found = r_found;
   assign out_first = r_first;
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
         r_sh    <= '0;
         r_len   <= '0;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_hits  <= '0;
         r_found <= 1'b0;
         r_first <= '0;
      end else begin
         case (r_state)
            IDLE: if (in_valid) begin
               r_sh    <= in_data;
               r_len   <= w_len;
               r_cnt   <= 4'(CLR_CYCLES - 1);
               r_idx   <= '0;
               r_hits  <= '0;
               r_found <= 1'b0;
               r_first <= '0;
               r_state <= (w_len == '0) ? REPORT : CLEAR;
            end
            CLEAR: begin
               r_cnt   <= r_cnt - 1'b1;
               r_state <= (r_cnt == '0) ? SHIFT : CLEAR;
            end
            SHIFT: begin
               r_sh    <= r_sh << 1;
               r_idx   <= r_idx + 1'b1;
               r_len   <= r_len - 1'b1;
               r_state <= (r_len == LW'(1)) ? REPORT : SHIFT;
               if (rec_z) begin
                  r_hits  <= r_hits + {3'd0, r_hits != 4'hF};
                  r_found <= 1'b1;
                  r_first <= r_found ? r_first : r_idx;
               end
            end
            default: r_state <= out_ready ? IDLE : REPORT;
         endcase
      end
   end
endmodule

// File: tb/tb_serial_frame_scheduler.sv
// tb_serial_frame_scheduler: directed bench for serial_frame_scheduler with CLR_CYCLES of 1 and 3
module tb_serial_frame_scheduler;
   typedef struct {
      logic [7:0] d;
      logic [3:0] l;
      int         el;
      logic [7:0] m;
      logic [3:0] h;
      logic       f;
      logic [2:0] fi;
   } frame_t;
   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] in_data = '0;
   logic [3:0] in_len = '0;
   logic       out_ready = 1'b0;
   logic       iv1 = 1'b0, rz1 = 1'b0, ir1, rx1, rc1, ov1, of1;
   logic [3:0] oh1;
   logic [2:0] ofi1;
   logic       iv3 = 1'b0, rz3 = 1'b0, ir3, rx3, rc3, ov3, of3;
   logic [3:0] oh3;
   logic [2:0] ofi3;
   int total = 0;
   int bad = 0;
   always #5 clock = ~clock;
   serial_frame_scheduler #(.DATA_W(8), .CLR_CYCLES(1)) u1 (
      .clock(clock), .reset(reset), .in_valid(iv1), .in_ready(ir1), .in_data(in_data),
      .in_len(in_len), .rec_x(rx1), .rec_clr_n(rc1), .rec_z(rz1), .out_valid(ov1),
      .out_ready(out_ready), .out_hits(oh1), .out_found(of1), .out_first(ofi1));
   serial_frame_scheduler #(.DATA_W(8), .CLR_CYCLES(3)) u3 (
      .clock(clock), .reset(reset), .in_valid(iv3), .in_ready(ir3), .in_data(in_data),
      .in_len(in_len), .rec_x(rx3), .rec_clr_n(rc3), .rec_z(rz3), .out_valid(ov3),
      .out_ready(out_ready), .out_hits(oh3), .out_found(of3), .out_first(ofi3));
   task automatic test_reset;
      #12;
      total++; if ({ir1, rc1, ov1, rx1} !== 4'b0000) begin bad++; $display("FAIL rst_ctrl act=%b req=0000", {ir1, rc1, ov1, rx1}); end
      total++; if ({oh1, of1, ofi1} !== 8'd0) begin bad++; $display("FAIL rst_result act=%h req=00", {oh1, of1, ofi1}); end
      total++; if ({ir3, rc3, ov3} !== 3'b000) begin bad++; $display("FAIL rst_u3 act=%b req=000", {ir3, rc3, ov3}); end
      @(negedge clock);
      reset = 1'b1;
      #1;
      total++; if ({ir1, rc1, ov1} !== 3'b110) begin bad++; $display("FAIL rst_release act=%b req=110", {ir1, rc1, ov1}); end
      total++; if ({ir3, rc3} !== 2'b11) begin bad++; $display("FAIL rst_release_u3 act=%b req=11", {ir3, rc3}); end
   endtask
   task automatic test_frames;
      frame_t tab[4];
      tab[0] = '{8'hB2, 4'd8, 8, 8'h00, 4'd0, 1'b0, 3'd0};
      tab[1] = '{8'hB2, 4'd8, 8, 8'b0010_0100, 4'd2, 1'b1, 3'd2};
      tab[2] = '{8'hA5, 4'd3, 3, 8'b0000_0110, 4'd2, 1'b1, 3'd1};
      tab[3] = '{8'h0F, 4'd15, 8, 8'h80, 4'd1, 1'b1, 3'd7};
      for (int k = 0; k < 4; k++) begin
         @(negedge clock);
         in_data = tab[k].d; in_len = tab[k].l; iv1 = 1'b1; rz1 = 1'b1;
         total++; if (ir1 !== 1'b1) begin bad++; $display("FAIL frame%0d_ready act=%b req=1", k, ir1); end
         @(negedge clock);
         iv1 = 1'b0; in_data = ~tab[k].d; in_len = 4'd1;
         total++; if ({rc1, rx1, ir1, ov1} !== 4'b0000) begin bad++; $display("FAIL frame%0d_clear act=%b req=0000", k, {rc1, rx1, ir1, ov1}); end
         @(negedge clock);
         for (int i = 0; i < tab[k].el; i++) begin
            total++; if ({rc1, rx1, ov1} !== {1'b1, tab[k].d[7-i], 1'b0}) begin bad++; $display("FAIL frame%0d_bit%0d act=%b req=%b", k, i, {rc1, rx1, ov1}, {1'b1, tab[k].d[7-i], 1'b0}); end
            rz1 = tab[k].m[i];
            @(negedge clock);
         end
         rz1 = 1'b1;
         total++; if ({ov1, ir1, rx1, rc1} !== 4'b1001) begin bad++; $display("FAIL frame%0d_report act=%b req=1001", k, {ov1, ir1, rx1, rc1}); end
         total++; if ({oh1, of1, ofi1} !== {tab[k].h, tab[k].f, tab[k].fi}) begin bad++; $display("FAIL frame%0d_result act=%h/%b/%0d req=%h/%b/%0d", k, oh1, of1, ofi1, tab[k].h, tab[k].f, tab[k].fi); end
         out_ready = 1'b1;
         @(negedge clock);
         out_ready = 1'b0; rz1 = 1'b0;
         total++; if ({ov1, ir1} !== 2'b01) begin bad++; $display("FAIL frame%0d_done act=%b req=01", k, {ov1, ir1}); end
      end
   endtask
   task automatic test_zero_len;
      @(negedge clock);
      in_len = 4'd0; in_data = 8'hFF; iv1 = 1'b1; rz1 = 1'b1;
      total++; if (rc1 !== 1'b1) begin bad++; $display("FAIL zl_clr_pre act=%b req=1", rc1); end
      @(negedge clock);
      iv1 = 1'b0;
      total++; if ({ov1, rc1, rx1} !== 3'b110) begin bad++; $display("FAIL zl_report act=%b req=110", {ov1, rc1, rx1}); end
      total++; if ({oh1, of1, ofi1} !== 8'd0) begin bad++; $display("FAIL zl_result act=%h req=00", {oh1, of1, ofi1}); end
      out_ready = 1'b1;
      @(negedge clock);
      out_ready = 1'b0; rz1 = 1'b0;
      total++; if ({ov1, rc1, ir1} !== 3'b011) begin bad++; $display("FAIL zl_done act=%b req=011", {ov1, rc1, ir1}); end
   endtask
   task automatic test_hold;
      @(negedge clock);
      in_data = 8'hC0; in_len = 4'd2; iv1 = 1'b1; rz1 = 1'b1;
      @(negedge clock);
      iv1 = 1'b0;
      repeat (3) @(negedge clock);
      total++; if ({ov1, oh1, of1, ofi1} !== {1'b1, 4'd2, 1'b1, 3'd0}) begin bad++; $display("FAIL hold_report act=%h req=%h", {ov1, oh1, of1, ofi1}, {1'b1, 4'd2, 1'b1, 3'd0}); end
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         total++; if ({ov1, ir1, oh1, of1, ofi1} !== {2'b10, 4'd2, 1'b1, 3'd0}) begin bad++; $display("FAIL hold_cycle%0d act=%h req=%h", i, {ov1, ir1, oh1, of1, ofi1}, {2'b10, 4'd2, 1'b1, 3'd0}); end
      end
      iv1 = 1'b1; out_ready = 1'b1;
      @(negedge clock);
      iv1 = 1'b0; out_ready = 1'b0; rz1 = 1'b0;
      total++; if ({ov1, ir1, rc1} !== 3'b011) begin bad++; $display("FAIL hold_release act=%b req=011", {ov1, ir1, rc1}); end
   endtask
   task automatic test_clr3;
      logic [7:0] d;
      d = 8'hB2;
      @(negedge clock);
      in_data = d; in_len = 4'd8; iv3 = 1'b1; rz3 = 1'b1;
      @(negedge clock);
      iv3 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         total++; if ({rc3, ov3, ir3} !== 3'b000) begin bad++; $display("FAIL clr3_clear%0d act=%b req=000", i, {rc3, ov3, ir3}); end
         @(negedge clock);
      end
      for (int i = 0; i < 8; i++) begin
         total++; if ({rc3, rx3, ov3} !== {1'b1, d[7-i], 1'b0}) begin bad++; $display("FAIL clr3_bit%0d act=%b req=%b", i, {rc3, rx3, ov3}, {1'b1, d[7-i], 1'b0}); end
         @(negedge clock);
      end
      total++; if ({ov3, oh3, of3, ofi3} !== {1'b1, 4'd8, 1'b1, 3'd0}) begin bad++; $display("FAIL clr3_result act=%h req=%h", {ov3, oh3, of3, ofi3}, {1'b1, 4'd8, 1'b1, 3'd0}); end
      out_ready = 1'b1;
      @(negedge clock);
      out_ready = 1'b0; rz3 = 1'b0;
      total++; if ({ov3, ir3} !== 2'b01) begin bad++; $display("FAIL clr3_done act=%b req=01", {ov3, ir3}); end
   endtask
   task automatic test_reset_mid;
      @(negedge clock);
      in_data = 8'hB2; in_len = 4'd8; iv1 = 1'b1; rz1 = 1'b1;
      @(negedge clock);
      iv1 = 1'b0;
      repeat (4) @(negedge clock);
      total++; if ({oh1, rx1} !== {4'd3, 1'b1}) begin bad++; $display("FAIL mid_before act=%h req=%h", {oh1, rx1}, {4'd3, 1'b1}); end
      #2 reset = 1'b0;
      #1;
      total++; if ({ov1, ir1, rc1, rx1} !== 4'b0000) begin bad++; $display("FAIL mid_async_ctrl act=%b req=0000", {ov1, ir1, rc1, rx1}); end
      total++; if ({oh1, of1, ofi1} !== 8'd0) begin bad++; $display("FAIL mid_async_result act=%h req=00", {oh1, of1, ofi1}); end
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         total++; if ({ov1, ir1, rc1} !== 3'b000) begin bad++; $display("FAIL mid_held%0d act=%b req=000", i, {ov1, ir1, rc1}); end
      end
      reset = 1'b1; rz1 = 1'b0;
      #1;
      total++; if ({ir1, rc1, ov1} !== 3'b110) begin bad++; $display("FAIL mid_release act=%b req=110", {ir1, rc1, ov1}); end
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         total++; if ({ov1, ir1} !== 2'b01) begin bad++; $display("FAIL mid_idle%0d act=%b req=01", i, {ov1, ir1}); end
      end
      test_frames();
   endtask
   initial begin
      test_reset();
      test_frames();
      test_zero_len();
      test_hold();
      test_clr3();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
